uart_tx: RTL
============

Name: uart_tx

Overview:
UART transmitter: serializes one parallel data byte into a standard asynchronous frame (start bit, data LSB-first, optional parity, stop bit) on a single TX line. It is the transmit-side counterpart of the UART_RX path in the same serial subsystem. It runs on the bit-rate clock (one clk per bit), so no prescale is needed inside the block. Upstream logic hands it bytes through a valid/busy handshake.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (supported range 5..9)

Ports:
clk  input  1  transmit bit clock, rising-edge active; one clk period = one bit time
reset_n  input  1  asynchronous, active-low reset
p_data  input  DATA_WIDTH  parallel data to transmit
data_valid  input  1  one-cycle request; p_data is valid when high
par_en  input  1  1 = insert parity bit after data bits
par_typ  input  1  0 = even parity, 1 = odd parity
tx_out  output  1  serial line, idles high
busy  output  1  high while a frame is in progress

Behaviour:
- Reset: the block is asynchronous-cleared to IDLE.
  - tx_out = 1, busy = 0.
  - Data shift register = 0, bit counter = 0, latched par_en/par_typ = 0.
- Internal blocks: FSM, serializer with shift register and bit counter, parity calculator, output mux.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out = 1, busy = 0.
  - When data_valid = 1 on a rising edge: latch p_data, par_en and par_typ, then go to START.
- START:
  - tx_out = 0, busy = 1, for 1 cycle.
  - Next state is DATA; bit counter is cleared.
- DATA:
  - tx_out = shift_reg[0], busy = 1.
  - Each cycle the register shifts right and the counter increments.
  - After DATA_WIDTH cycles (counter == DATA_WIDTH-1 on the last one), go to PARITY if the latched par_en = 1, else go to STOP.
- PARITY:
  - Even: tx_out = XOR of the latched data. Odd: tx_out = the inverse of that XOR.
  - Parity is computed from the latched copy, not the shifted register.
  - Lasts 1 cycle, then go to STOP.
- STOP:
  - tx_out = 1, busy = 1, for 1 cycle.
  - If data_valid = 1 in this cycle, latch the new data and go directly to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.
- Latency:
  - tx_out falls to 0 (start bit) on the clk edge that samples data_valid.
  - Frame length is 1+DATA_WIDTH+1 cycles without parity, or 1+DATA_WIDTH+2 cycles with parity.
- Output timing:
  - tx_out and busy are registered; there are no combinational paths from inputs to outputs.
  - busy rises on the same edge as the start bit.
  - busy falls on the edge that leaves STOP for IDLE.
- data_valid outside IDLE/STOP is ignored and is not queued. Upstream must wait for busy = 0, or present data in the STOP cycle.
- Changes to p_data, par_en or par_typ during a frame have no effect; only the values latched at the start are used.
- Reset asserted mid-frame: outputs go to idle immediately. After reset is released, no partial frame resumes.
- Undefined state encodings recover to IDLE.

Test Plan:
- Reset, then p_data = 8'hA5, par_en = 0, one-cycle data_valid → tx_out sequence 0,1,0,1,0,0,1,0,1,1; busy high for exactly 10 cycles.
- p_data = 8'hA5, par_en = 1, par_typ = 0 → 11-bit frame, parity bit = 0. Repeat with par_typ = 1 → parity bit = 1.
- p_data = 8'h01, par_en = 1, par_typ = 0 (even) → parity bit = 1. Repeat with 8'hFF → parity bit = 0.
- Back-to-back: data_valid with 8'h55, then data_valid again in the STOP cycle with 8'h0F → the second start bit follows the stop bit with no idle cycle, and busy stays high throughout.
- data_valid pulsed during DATA and p_data changed mid-frame → current frame unchanged, no extra frame sent.
- reset_n dropped during the 4th data bit → tx_out = 1 and busy = 0 immediately. After release, the line stays idle until a new data_valid.

Source files
------------

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//   UART transmitter running on the bit-rate clock (one clk per bit).
//   It serializes one byte per frame: a start bit (0), DATA_WIDTH data bits
//   LSB first, an optional parity bit, then a stop bit (1).
//
// Ports
//   clk         bit clock, rising-edge active
//   reset_n     asynchronous, active-low reset
//   p_data      parallel data, sampled when data_valid is high in IDLE/STOP
//   data_valid  one-cycle transmit request
//   par_en      1 = append a parity bit after the data bits
//   par_typ     0 = even parity, 1 = odd parity
//   tx_out      serial line (registered), idles high
//   busy        high while a frame is on the line (registered)
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] data_lat;   // unshifted copy, feeds the parity bit
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bit;

    // Even parity is the XOR of the data; odd parity is its inverse.
    assign par_bit = (^data_lat) ^ par_typ_q;

    // tx_out/busy are registered alongside the state, so each value is
    // the one that belongs to the state being entered on this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            data_lat  <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        shift_reg <= p_data;
                        data_lat  <= p_data;
                        par_en_q  <= par_en;
                        par_typ_q <= par_typ;
                        state     <= START;
                        tx_out    <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        tx_out    <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                START: begin
                    // Present bit 0 now and pre-shift so shift_reg[0] is the
                    // next bit on each following DATA edge.
                    state     <= DATA;
                    bit_cnt   <= '0;
                    tx_out    <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                    busy      <= 1'b1;
                end

                DATA: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    busy    <= 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_q) begin
                            state  <= PARITY;
                            tx_out <= par_bit;
                        end else begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end
                    end else begin
                        tx_out    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end

                PARITY: begin
                    state  <= STOP;
                    tx_out <= 1'b1;
                    busy   <= 1'b1;
                end

                STOP: begin
                    // A request during the stop bit chains the next frame
                    // with no idle gap.
                    if (data_valid) begin
                        shift_reg <= p_data;
                        data_lat  <= p_data;
                        par_en_q  <= par_en;
                        par_typ_q <= par_typ;
                        state     <= START;
                        tx_out    <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        tx_out    <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
